// File: rtl/uart_frame_rx.sv
// uart_frame_rx: byte-level frame decoder behind a UART receiver.
// Frame format: SOF, LEN, PAYLOAD[LEN], CHK where CHK = LEN ^ payload bytes.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   rx_done_tick      - one-cycle strobe, rx_dout holds a new byte
//   rx_dout           - received byte
//   s_tick            - 16x baud oversampling tick, drives the inter-byte timeout
//   rd_addr / rd_data - combinational read port into the payload buffer
//   frame_len         - payload length of the last accepted frame
//   frame_valid       - one-cycle pulse, frame accepted
//   frame_err         - one-cycle pulse, frame rejected
//   err_code          - last error cause: 0 none, 1 length, 2 checksum, 3 timeout
//   busy              - high whenever a frame is in progress
module uart_frame_rx #(
  parameter int unsigned     DBIT          = 8,
  parameter int unsigned     MAX_LEN       = 16,
  parameter logic [DBIT-1:0] SOF           = DBIT'(8'hA5),
  parameter int unsigned     TIMEOUT_TICKS = 480
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_done_tick,
  input  logic [DBIT-1:0]            rx_dout,
  input  logic                       s_tick,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [DBIT-1:0]            rd_data,
  output logic [7:0]                 frame_len,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      index_q, index_d;
  logic [7:0]      len_q, len_d;
  logic [DBIT-1:0] acc_q, acc_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [7:0]      frame_len_q, frame_len_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;

  logic [DBIT-1:0] buf_q [MAX_LEN];
  logic            wr_en_c;
  logic            timeout_hit_c;

  // Expiry fires on the tick that would take the counter to TIMEOUT_TICKS.
  assign timeout_hit_c = s_tick && (tcnt_q == TW'(TIMEOUT_TICKS - 1));

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    len_d         = len_q;
    acc_d         = acc_q;
    tcnt_d        = tcnt_q;
    frame_len_d   = frame_len_q;
    err_code_d    = err_code_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    wr_en_c       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_done_tick && (rx_dout == SOF)) begin
          state_d = S_LEN;
          tcnt_d  = '0;
        end
      end
      S_LEN: begin
        if (rx_done_tick) begin
          if ((rx_dout == '0) || (rx_dout > DBIT'(MAX_LEN))) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d   = 8'(rx_dout);
            acc_d   = rx_dout;
            index_d = 8'd0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_done_tick) begin
          wr_en_c = 1'b1;
          acc_d   = acc_q ^ rx_dout;
          index_d = index_q + 8'd1;
          if (index_q == (len_q - 8'd1)) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rx_done_tick) begin
          state_d = S_IDLE;
          if (rx_dout == acc_q) begin
            frame_valid_d = 1'b1;
            frame_len_d   = len_q;
            err_code_d    = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; a byte arriving on the expiring tick takes priority.
    if (state_q != S_IDLE) begin
      if (rx_done_tick) begin
        tcnt_d = '0;
      end else if (s_tick) begin
        if (timeout_hit_c) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      index_q       <= '0;
      len_q         <= '0;
      acc_q         <= '0;
      tcnt_q        <= '0;
      frame_len_q   <= '0;
      err_code_q    <= ERR_NONE;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      len_q         <= len_d;
      acc_q         <= acc_d;
      tcnt_q        <= tcnt_d;
      frame_len_q   <= frame_len_d;
      err_code_q    <= err_code_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  // Payload buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      buf_q[AW'(index_q)] <= rx_dout;
    end
  end

  assign rd_data     = buf_q[rd_addr];
  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = busy_q;

endmodule
